// File: rtl/asm_mac_engine.sv
// Shift-add multiply-accumulate engine: R = S +/- in1*in2 (mod 2^WIDTH).
// A three-state control FSM drives load/accumulate/shift enables into the data path.
module asm_mac_engine #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned EARLY_EXIT = 1,
    localparam int unsigned CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] R3,
    output logic [WIDTH-1:0] R4,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   r3_q, r3_d;
    logic [WIDTH-1:0]   r4_q, r4_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               enable_load;
    logic               enable_acc;
    logic               enable_shift;

    // Control unit: next state and per-register enables.
    always_comb begin
        state_d      = state_q;
        enable_load  = 1'b0;
        enable_acc   = 1'b0;
        enable_shift = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    enable_load = 1'b1;
                    state_d     = StCalc;
                end
            end
            StCalc: begin
                // Remaining multiplier bits are all zero: nothing left to add.
                if ((EARLY_EXIT != 0) && (r4_q == '0)) begin
                    state_d = StDone;
                end else begin
                    enable_shift = 1'b1;
                    enable_acc   = r4_q[0];
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Data path: register next values selected by the control enables.
    always_comb begin
        r3_d  = r3_q;
        r4_d  = r4_q;
        acc_d = acc_q;
        op_d  = op_q;
        cnt_d = cnt_q;
        if (enable_load) begin
            r3_d  = in1;
            r4_d  = in2;
            acc_d = S;
            op_d  = op;
            cnt_d = '0;
        end
        if (enable_shift) begin
            r3_d  = r3_q << 1;
            r4_d  = r4_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (enable_acc) begin
            acc_d = op_q ? (acc_q - r3_q) : (acc_q + r3_q);
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            r3_q    <= '0;
            r4_q    <= '0;
            acc_q   <= '0;
            op_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r3_q    <= r3_d;
            r4_q    <= r4_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign R3   = r3_q;
    assign R4   = r4_q;
    assign R    = acc_q;
    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_asm_mac_engine.sv
// Directed bench for asm_mac_engine: three instances (8-bit full-length, 8-bit early-exit,
// 32-bit early-exit) checked against an arithmetic model through a result scoreboard.
module tb_asm_mac_engine;

    typedef struct {
        logic [31:0] r;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start = '0;
    logic        op = 1'b0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic [31:0] s_in = '0;

    logic [7:0]  r3_0, r4_0, r_0;
    logic [7:0]  r3_1, r4_1, r_1;
    logic [31:0] r3_2, r4_2, r_2;
    logic [2:0]  busy_w, done_w;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    asm_mac_engine #(.WIDTH(8), .EARLY_EXIT(0)) u_w8 (
        .clk(clk), .rst(rst), .start(start[0]), .op(op), .in1(in1[7:0]), .in2(in2[7:0]),
        .S(s_in[7:0]), .R3(r3_0), .R4(r4_0), .R(r_0), .busy(busy_w[0]), .done(done_w[0])
    );

    asm_mac_engine #(.WIDTH(8), .EARLY_EXIT(1)) u_w8e (
        .clk(clk), .rst(rst), .start(start[1]), .op(op), .in1(in1[7:0]), .in2(in2[7:0]),
        .S(s_in[7:0]), .R3(r3_1), .R4(r4_1), .R(r_1), .busy(busy_w[1]), .done(done_w[1])
    );

    asm_mac_engine #(.WIDTH(32), .EARLY_EXIT(1)) u_w32 (
        .clk(clk), .rst(rst), .start(start[2]), .op(op), .in1(in1), .in2(in2),
        .S(s_in), .R3(r3_2), .R4(r4_2), .R(r_2), .busy(busy_w[2]), .done(done_w[2])
    );

    function automatic logic [31:0] r_of(input int idx);
        if (idx == 0) return {24'b0, r_0};
        if (idx == 1) return {24'b0, r_1};
        return r_2;
    endfunction

    function automatic logic [31:0] r4_of(input int idx);
        if (idx == 0) return {24'b0, r4_0};
        if (idx == 1) return {24'b0, r4_1};
        return r4_2;
    endfunction

    function automatic int width_of(input int idx);
        return (idx == 2) ? 32 : 8;
    endfunction

    // Expected cycles from the accepting edge to the edge after which done is high.
    function automatic int exp_lat(input int w, input bit ee, input logic [31:0] b);
        int msb = -1;
        for (int i = 0; i < w; i++) if (b[i]) msb = i;
        if (!ee) return w;
        if (msb < 0) return 1;
        return (msb + 2 > w) ? w : msb + 2;
    endfunction

    function automatic exp_t model(input int idx, input logic o, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] s);
        exp_t        e;
        logic [63:0] full;
        logic [63:0] prod;
        prod = {32'b0, a} * {32'b0, b};
        full = o ? ({32'b0, s} - prod) : ({32'b0, s} + prod);
        e.r   = (width_of(idx) == 32) ? full[31:0] : {24'b0, full[7:0]};
        e.lat = exp_lat(width_of(idx), idx != 0, b);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Wait for done on an instance, then compare against the oldest scoreboard entry.
    task automatic wait_done(input int idx, input string tag);
        exp_t e;
        int   lat = 0;
        int   ndone = 0;
        while (lat < 100 && ndone == 0) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done_w[idx]) ndone++;
        end
        e = sb.pop_front();
        check({tag, "_done_seen"}, 32'(ndone), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        check({tag, "_result"}, r_of(idx), e.r);
        check({tag, "_busy_at_done"}, {31'b0, busy_w[idx]}, 32'd1);
        if (idx == 0) check({tag, "_r4_drained"}, r4_of(idx), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_busy_after"}, {31'b0, busy_w[idx]}, 32'd0);
        check({tag, "_done_after"}, {31'b0, done_w[idx]}, 32'd0);
    endtask

    task automatic run(input int idx, input logic o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] s, input string tag);
        sb.push_back(model(idx, o, a, b, s));
        @(negedge clk);
        op = o; in1 = a; in2 = b; s_in = s;
        start[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[idx] = 1'b0;
        check({tag, "_busy_launch"}, {31'b0, busy_w[idx]}, 32'd1);
        wait_done(idx, tag);
    endtask

    initial begin
        int ndone;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_r_w8", {24'b0, r_0}, 32'd0);
        check("rst_r3_w8e", {24'b0, r3_1}, 32'd0);
        check("rst_r4_w8e", {24'b0, r4_1}, 32'd0);
        check("rst_regs_w32", r3_2 | r4_2 | r_2, 32'd0);
        check("rst_busy", {29'b0, busy_w}, 32'd0);
        check("rst_done", {29'b0, done_w}, 32'd0);
        check("rst_r3_w8", {24'b0, r3_0}, 32'd0);
        rst = 1'b0;

        run(0, 1'b0, 32'd13, 32'd11, 32'd5, "mac_basic");
        run(0, 1'b0, 32'd200, 32'd200, 32'd0, "mac_wrap");
        run(0, 1'b1, 32'd3, 32'd4, 32'd100, "sub_pos");
        run(0, 1'b1, 32'd3, 32'd4, 32'd5, "sub_neg");
        run(1, 1'b0, 32'd9, 32'd2, 32'd1, "ee_in2_2");
        run(1, 1'b0, 32'd77, 32'd0, 32'd42, "ee_in2_0");
        run(1, 1'b1, 32'd255, 32'd128, 32'd7, "ee_msb");
        run(2, 1'b0, 32'hDEAD_BEEF, 32'h0001_2345, 32'h1111_1111, "w32_add");

        // Start held high across a run with operands changed after launch
        sb.push_back(model(0, 1'b0, 32'd13, 32'd11, 32'd5));
        @(negedge clk);
        op = 1'b0; in1 = 32'd13; in2 = 32'd11; s_in = 32'd5;
        start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in1 = 32'd7; in2 = 32'd3; s_in = 32'd2;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_w[0]) ndone++;
        end
        check("hold_done_once", 32'(ndone), 32'd1);
        check("hold_done_at_k8", {31'b0, done_w[0]}, 32'd1);
        check("hold_result_launch_ops", {24'b0, r_0}, sb.pop_front().r);
        @(posedge clk);
        @(negedge clk);
        check("hold_idle_busy", {31'b0, busy_w[0]}, 32'd0);
        check("hold_idle_done", {31'b0, done_w[0]}, 32'd0);
        sb.push_back(model(0, 1'b0, 32'd7, 32'd3, 32'd2));
        @(posedge clk);
        @(negedge clk);
        check("hold_reaccept_busy", {31'b0, busy_w[0]}, 32'd1);
        start[0] = 1'b0;
        wait_done(0, "hold_second");

        // Reset in the middle of a 32-bit run
        @(negedge clk);
        op = 1'b0; in1 = 32'h1234_5678; in2 = 32'hFFFF_FFFF; s_in = 32'h0000_0099;
        start[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("midrst_busy_before", {31'b0, busy_w[2]}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_r3", r3_2, 32'd0);
        check("midrst_r4", r4_2, 32'd0);
        check("midrst_r", r_2, 32'd0);
        check("midrst_busy", {31'b0, busy_w[2]}, 32'd0);
        check("midrst_done", {31'b0, done_w[2]}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_w[2] || busy_w[2]) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        run(2, 1'b1, 32'h0BAD_F00D, 32'h8000_0003, 32'h0000_0010, "midrst_fresh");

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
